// File: rtl/uart_byte_tx_if.sv
// Byte-producer side of the UART transmitter.
// Groups the accept handshake and the flow-control hold into one bundle.
//
// Handshake: the producer may present a byte on data with new_data=1 in any
// cycle where busy=0; the byte is taken on that rising clock edge, and busy
// reads 1 from the next cycle until the frame has finished. A request made
// while busy=1 is dropped, not queued. block=1 holds off new frames: busy
// goes high one cycle later and stays high while block is held.
interface uart_byte_tx_if;
    logic [7:0] data;
    logic       new_data;
    logic       block;
    logic       busy;

    // Producer / flow-control side.
    modport master (
        output data,
        output new_data,
        output block,
        input  busy
    );

    // Transmitter side.
    modport slave (
        input  data,
        input  new_data,
        input  block,
        output busy
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: one start bit (low), eight data bits LSB first,
// one stop bit (high). Every output comes straight from a flop, so there is
// no combinational path from data/new_data/block to tx or busy.
module uart_byte_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_byte_tx_if.slave        bus,
    output logic                 tx,
    output logic [1:0]           state_dbg
);

    // Clock cycles per serial bit, rounded to the nearest integer.
    localparam int CLK_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW          = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc_cnt;   // cycles spent in the current bit
    logic [2:0]    bit_idx;   // data bit being sent
    logic [7:0]    shift_q;   // bit 0 is always the data bit on the line
    logic          block_q;   // flow-control hold, registered once

    // A request is taken only in IDLE when nothing holds it off. In IDLE
    // busy tracks block_q (apart from the first IDLE cycle after a frame,
    // where busy is still high), so busy=0 always means "a request now will
    // be accepted".
    logic accept;
    assign accept = (state == IDLE) && bus.new_data && !block_q && !bus.busy;

    // Frame sequencer: state, line level, busy flag and bit timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            bus.busy <= 1'b0;
            cyc_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            block_q  <= 1'b0;
        end else begin
            block_q <= bus.block;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q  <= bus.data;
                        cyc_cnt  <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= START;
                    end else begin
                        tx       <= 1'b1;
                        // Follows the same input block_q samples, so busy and
                        // block_q agree from the next cycle on.
                        bus.busy <= bus.block;
                    end
                end

                START: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift_q[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                STOP: begin
                    // busy stays high through this state and the first IDLE
                    // cycle, which guarantees an idle-high gap between frames.
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    bus.busy <= 1'b0;
                    cyc_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: a fast instance (10 clocks per bit) checked by a
// frame monitor against an expected-byte queue, plus a default-rate instance
// whose bit timing is measured directly.
module tb_uart_byte_tx;

    logic clk;
    logic rst;

    uart_byte_tx_if f_if ();
    uart_byte_tx_if s_if ();

    logic       f_tx;
    logic       s_tx;
    logic [1:0] f_state;
    logic [1:0] s_state;

    // CLK_FREQ=1000, BAUD=100 gives 10 clocks per bit.
    uart_byte_tx #(.CLK_FREQ(1000), .BAUD(100)) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .bus       (f_if.slave),
        .tx        (f_tx),
        .state_dbg (f_state)
    );

    // Default 100 MHz / 115200 gives 868 clocks per bit.
    uart_byte_tx dut_slow (
        .clk       (clk),
        .rst       (rst),
        .bus       (s_if.slave),
        .tx        (s_tx),
        .state_dbg (s_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int checks;
    int failures;
    int frames_done;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame monitor for the fast instance: on each start bit, pop the expected
    // byte and compare all 100 frame samples plus the idle sample that follows.
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       lvl;
        int         bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && f_tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_frame", 0, 1);
                    for (int k = 0; k < 200 && f_tx !== 1'b1; k++) @(negedge clk);
                end else begin
                    exp_b   = exp_q.pop_front();
                    got_b   = '0;
                    bad     = 0;
                    aborted = 1'b0;
                    for (int k = 0; k <= 100; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k < 10)      lvl = 1'b0;
                        else if (k < 90) lvl = exp_b[(k - 10) / 10];
                        else             lvl = 1'b1;
                        if (f_tx !== lvl) bad++;
                        if (k >= 10 && k < 90 && (k % 10) == 5) got_b[(k - 10) / 10] = f_tx;
                    end
                    if (!aborted) begin
                        check(bad == 0, "frame_shape", bad, 0);
                        check(got_b === exp_b, "frame_byte", int'(got_b), int'(exp_b));
                        frames_done++;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (f_if.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(n < 3000, name, n, 0);
    endtask

    // Waits for busy=0, issues one request and returns at the first
    // negedge after the accepting edge (first sample of the start bit).
    task automatic send_byte(input logic [7:0] b);
        wait_idle("send_wait");
        f_if.data     = b;
        f_if.new_data = 1'b1;
        @(posedge clk);
        exp_q.push_back(b);
        @(negedge clk);
        f_if.new_data = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        int n;
        int f0;
        int lows;
        int len;
        int total;
        int bad_runs;
        logic lvl;
        logic [7:0] msg [3];

        checks      = 0;
        failures    = 0;
        frames_done = 0;
        rst = 1'b1;
        f_if.data = '0; f_if.new_data = 1'b0; f_if.block = 1'b0;
        s_if.data = '0; s_if.new_data = 1'b0; s_if.block = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check(f_tx === 1'b1, "reset_tx", f_tx, 1);
        check(f_if.busy === 1'b0, "reset_busy", f_if.busy, 0);
        check(f_state === 2'd0, "reset_state", f_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5 with busy timing
        f0 = frames_done;
        send_byte(8'hA5);
        check(f_if.busy === 1'b1, "accept_busy", f_if.busy, 1);
        check(f_tx === 1'b0, "accept_tx_low", f_tx, 0);
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (f_if.busy !== 1'b1) break;
            n++;
        end
        check(n == 101, "busy_len", n, 101);
        check(frames_done - f0 == 1, "a5_frames", frames_done - f0, 1);

        // Back-to-back "T", CR, LF
        msg[0] = 8'h54; msg[1] = 8'h0D; msg[2] = 8'h0A;
        f0 = frames_done;
        for (int i = 0; i < 3; i++) send_byte(msg[i]);
        wait_idle("b2b_idle");
        check(frames_done - f0 == 3, "b2b_frames", frames_done - f0, 3);

        // Request mid-frame must be ignored
        f0 = frames_done;
        send_byte(8'h3C);
        repeat (30) @(negedge clk);
        f_if.data     = 8'h99;
        f_if.new_data = 1'b1;
        @(negedge clk);
        f_if.new_data = 1'b0;
        f_if.data     = 8'hEE;
        check(f_state === 2'd2, "midframe_state", f_state, 2);
        send_byte(8'h81);
        wait_idle("midframe_idle");
        check(frames_done - f0 == 2, "midframe_frames", frames_done - f0, 2);

        // block while idle
        f0 = frames_done;
        f_if.block = 1'b1;
        @(negedge clk);
        check(f_if.busy === 1'b1, "block_busy_rise", f_if.busy, 1);
        f_if.data     = 8'h77;
        f_if.new_data = 1'b1;
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (f_tx !== 1'b1) lows++;
        end
        f_if.new_data = 1'b0;
        check(lows == 0, "block_tx_idle", lows, 0);
        check(f_state === 2'd0, "block_state_idle", f_state, 0);
        f_if.block = 1'b0;
        @(negedge clk);
        check(f_if.busy === 1'b0, "block_busy_fall", f_if.busy, 0);
        send_byte(8'h5A);
        wait_idle("block_idle");
        check(frames_done - f0 == 1, "block_frames", frames_done - f0, 1);

        // block raised mid-frame: frame completes, then busy held
        f0 = frames_done;
        send_byte(8'hC3);
        repeat (20) @(negedge clk);
        f_if.block = 1'b1;
        repeat (100) @(negedge clk);
        check(f_if.busy === 1'b1, "block_hold_busy", f_if.busy, 1);
        check(f_state === 2'd0, "block_hold_state", f_state, 0);
        check(frames_done - f0 == 1, "block_hold_frames", frames_done - f0, 1);
        f_if.block = 1'b0;
        @(negedge clk);
        check(f_if.busy === 1'b0, "block_hold_release", f_if.busy, 0);

        // Reset mid-frame aborts at once
        f0 = frames_done;
        send_byte(8'hF0);
        repeat (35) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check(f_tx === 1'b1, "rst_mid_tx", f_tx, 1);
        check(f_if.busy === 1'b0, "rst_mid_busy", f_if.busy, 0);
        check(f_state === 2'd0, "rst_mid_state", f_state, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        send_byte(8'h0F);
        wait_idle("rst_fresh_idle");
        check(frames_done - f0 == 1, "rst_fresh_frames", frames_done - f0, 1);

        // Default rate, byte 0x55: line alternates every bit
        s_if.data     = 8'h55;
        s_if.new_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_if.new_data = 1'b0;
        check(s_tx === 1'b0, "slow_start_low", s_tx, 0);
        lvl      = 1'b0;
        total    = 0;
        bad_runs = 0;
        for (int r = 0; r < 9; r++) begin
            len = 0;
            while (s_tx === lvl && len < 2000) begin
                len++;
                @(negedge clk);
            end
            if (r == 0) check(len == 868, "slow_start_len", len, 868);
            if (len != 868) bad_runs++;
            total += len;
            lvl = ~lvl;
        end
        check(bad_runs == 0, "slow_bit_period", bad_runs, 0);
        len = 0;
        while (s_tx === 1'b1 && s_if.busy === 1'b1 && len < 2000) begin
            len++;
            @(negedge clk);
        end
        check(len == 869, "slow_stop_len", len, 869);
        total += len - 1;
        check(total == 8680, "slow_frame_len", total, 8680);

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Asynchronous serial (UART) transmitter: serialises one 8-bit byte per request as an 8N1 frame (1 start, 8 data LSB-first, 1 stop, no parity) on a single line. It sits between byte-producing logic (e.g. a message/character sequencer) and the USB-serial bridge pin. A busy/handshake interface lets the producer issue one byte whenever the transmitter is free. A block input lets downstream flow control hold off new frames.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 115200, serial bit rate in bits/s.
CLK_PER_BIT (derived localparam) = (CLK_FREQ + BAUD/2) / BAUD, i.e. rounded; 868 for the defaults.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
tx  output  1  serial line; idle/stop level high, start level low.
busy  output  1  high when a new byte cannot be accepted.
data  input  8  byte to send, sampled only on the accept cycle.
new_data  input  1  single-cycle (or level) request to send data.
block  input  1  flow-control hold; while high no new frame starts.

Behaviour:
- Reset (async, active-high): state=IDLE, tx=1, busy=0, bit counter=0, cycle counter=0, block register=0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- block is registered once (block_q) before use; its effect lags by one clock.
- All outputs registered; no combinational path from inputs to tx/busy.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. If block_q=1, busy=1 and new_data is ignored. Otherwise busy=0; on a clock edge with new_data=1, latch data into a shift register, clear counters, go to START, set busy=1 (visible the next cycle).
- START: tx=0 for exactly CLK_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=data[bit index] for CLK_PER_BIT cycles per bit, bits 0..7 (LSB first). After bit 7, go to STOP.
- STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE.
- busy stays 1 from the cycle after accept through STOP and the first IDLE cycle. It falls one cycle after entering IDLE, unless block_q=1.
- Frame length: tx low edge occurs one cycle after the accepting edge. Total frame is 10*CLK_PER_BIT cycles.
- Minimum gap between frames: at least 1 idle-high cycle.
- new_data while busy/not IDLE: ignored; no queueing. Changing data mid-frame has no effect.
- block asserted mid-frame: the current frame completes normally, then busy stays 1 in IDLE until block deasserts.
- Simultaneous block rise and new_data in IDLE: the request is accepted, because block_q is still 0.
- Cycle counter width: ceil(log2(CLK_PER_BIT)); it wraps to 0 at CLK_PER_BIT-1. Bit index is 3 bits.

Test Plan:
- Reset: assert rst mid-frame (CLK_FREQ=1000, BAUD=100, CLK_PER_BIT=10) -> tx=1, busy=0 immediately; new_data after release starts a fresh frame.
- Single byte 0xA5 at CLK_PER_BIT=10 -> tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. busy rises 1 cycle after accept and falls 1 cycle after STOP ends.
- Back-to-back "T","\r","\n" driven by a producer that pulses new_data whenever busy=0 -> three contiguous frames decode correctly, separated by >=1 idle-high cycle; no byte lost or duplicated.
- new_data pulsed mid-frame with a different byte -> ignored; line and the next frame unaffected.
- block=1 while idle -> busy=1 one cycle later, new_data ignored, tx stays high. Release block -> busy=0 one cycle later, and the next request transmits.
- Default parameters (100 MHz, 115200) send byte 0x55 -> each bit period measures 868 clock cycles, frame is 8680 cycles.
